// File: rtl/gl_raster_edge_if.sv
// Triangle-in / pixel-out handshake bundle for the edge-function rasterizer.
// The master side supplies triangles and sinks pixels; the slave side is the rasterizer.
interface gl_raster_edge_if #(
   parameter int COORD_W = 12
);
   logic                      tri_valid;
   logic                      tri_ready;
   logic signed [COORD_W-1:0] tri_x0;
   logic signed [COORD_W-1:0] tri_y0;
   logic signed [COORD_W-1:0] tri_x1;
   logic signed [COORD_W-1:0] tri_y1;
   logic signed [COORD_W-1:0] tri_x2;
   logic signed [COORD_W-1:0] tri_y2;
   logic                      cull_back;
   logic                      pix_valid;
   logic                      pix_ready;
   logic [15:0]               pix_x;
   logic [15:0]               pix_y;

   modport master (
      output tri_valid, tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, cull_back, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y
   );

   modport slave (
      input  tri_valid, tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, cull_back, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y
   );
endinterface

// File: rtl/gl_raster_edge.sv
// Fixed-point triangle rasterizer: walks the screen-clipped bounding box one candidate
// pixel per cycle, tests coverage with incremental edge functions, and streams covered
// pixels out in raster order with valid/ready back-pressure.
module gl_raster_edge #(
   parameter int COORD_W  = 12,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic             clk,
   input  logic             rst,
   gl_raster_edge_if.slave  rasterBus,
   output logic             busy_o,
   output logic             tri_done_o
);
   localparam int EDGE_W = 2*COORD_W + 3;
   localparam int CNT_W  = COORD_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef logic signed [EDGE_W-1:0] edge_t;
   typedef enum logic [2:0] {IDLE, SETUP, INIT, SCAN, DONE} state_t;

   state_t           state_q;
   edge_t            x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
   logic             cull_q, areaNeg_q, lastSeen_q;
   logic [CNT_W-1:0] minX_q, maxX_q, minY_q, maxY_q, curX_q, curY_q;
   edge_t            e0_q, e1_q, e2_q, row0_q, row1_q, row2_q;
   edge_t            stepX0_q, stepX1_q, stepX2_q, stepY0_q, stepY1_q, stepY2_q;
   logic             triReady_q, pixValid_q, busy_q, triDone_q;
   logic [CNT_W-1:0] pixX_q, pixY_q;

   edge_t area_d, bbMinX_d, bbMaxX_d, bbMinY_d, bbMaxY_d;
   edge_t init0_d, init1_d, init2_d, px_d, py_d;
   logic  reject_d, covered_d, lastCand_d, advance_d;

   function automatic edge_t min3(input edge_t a, input edge_t b, input edge_t c);
      edge_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic edge_t max3(input edge_t a, input edge_t b, input edge_t c);
      edge_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Setup math (area, clipped bbox, reject), start-pixel edge values, and per-candidate coverage
   always_comb begin
      area_d   = (x1_q - x0_q) * (y2_q - y0_q) - (y1_q - y0_q) * (x2_q - x0_q);
      bbMinX_d = min3(x0_q, x1_q, x2_q);
      bbMaxX_d = max3(x0_q, x1_q, x2_q);
      bbMinY_d = min3(y0_q, y1_q, y2_q);
      bbMaxY_d = max3(y0_q, y1_q, y2_q);
      if (bbMinX_d < edge_t'(0)) bbMinX_d = edge_t'(0);
      if (bbMinY_d < edge_t'(0)) bbMinY_d = edge_t'(0);
      if (bbMaxX_d > edge_t'(SCREEN_W - 1)) bbMaxX_d = edge_t'(SCREEN_W - 1);
      if (bbMaxY_d > edge_t'(SCREEN_H - 1)) bbMaxY_d = edge_t'(SCREEN_H - 1);
      reject_d = (area_d == edge_t'(0)) || (area_d[EDGE_W-1] && cull_q) ||
                 (bbMinX_d > bbMaxX_d) || (bbMinY_d > bbMaxY_d);

      px_d    = edge_t'(minX_q);
      py_d    = edge_t'(minY_q);
      init0_d = (x1_q - x0_q) * (py_d - y0_q) - (y1_q - y0_q) * (px_d - x0_q);
      init1_d = (x2_q - x1_q) * (py_d - y1_q) - (y2_q - y1_q) * (px_d - x1_q);
      init2_d = (x0_q - x2_q) * (py_d - y2_q) - (y0_q - y2_q) * (px_d - x2_q);
      if (areaNeg_q) begin
         init0_d = -init0_d;
         init1_d = -init1_d;
         init2_d = -init2_d;
      end

      covered_d  = !e0_q[EDGE_W-1] && !e1_q[EDGE_W-1] && !e2_q[EDGE_W-1];
      lastCand_d = (curX_q == maxX_q) && (curY_q == maxY_q);
      advance_d  = !(pixValid_q && !rasterBus.pix_ready);
   end

   // Control FSM with registered handshake/status outputs and the incremental edge walker
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         triReady_q <= 1'b1;
         pixValid_q <= 1'b0;
         pixX_q     <= '0;
         pixY_q     <= '0;
         busy_q     <= 1'b0;
         triDone_q  <= 1'b0;
         lastSeen_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               triDone_q <= 1'b0;
               if (rasterBus.tri_valid && triReady_q) begin
                  x0_q       <= edge_t'(rasterBus.tri_x0);
                  y0_q       <= edge_t'(rasterBus.tri_y0);
                  x1_q       <= edge_t'(rasterBus.tri_x1);
                  y1_q       <= edge_t'(rasterBus.tri_y1);
                  x2_q       <= edge_t'(rasterBus.tri_x2);
                  y2_q       <= edge_t'(rasterBus.tri_y2);
                  cull_q     <= rasterBus.cull_back;
                  triReady_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= SETUP;
               end
            end
            SETUP: begin
               areaNeg_q <= area_d[EDGE_W-1];
               minX_q    <= bbMinX_d[CNT_W-1:0];
               maxX_q    <= bbMaxX_d[CNT_W-1:0];
               minY_q    <= bbMinY_d[CNT_W-1:0];
               maxY_q    <= bbMaxY_d[CNT_W-1:0];
               stepX0_q  <= area_d[EDGE_W-1] ? (y1_q - y0_q) : (y0_q - y1_q);
               stepX1_q  <= area_d[EDGE_W-1] ? (y2_q - y1_q) : (y1_q - y2_q);
               stepX2_q  <= area_d[EDGE_W-1] ? (y0_q - y2_q) : (y2_q - y0_q);
               stepY0_q  <= area_d[EDGE_W-1] ? (x0_q - x1_q) : (x1_q - x0_q);
               stepY1_q  <= area_d[EDGE_W-1] ? (x1_q - x2_q) : (x2_q - x1_q);
               stepY2_q  <= area_d[EDGE_W-1] ? (x2_q - x0_q) : (x0_q - x2_q);
               if (reject_d) begin
                  triDone_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  state_q   <= INIT;
               end
            end
            INIT: begin
               e0_q       <= init0_d;
               e1_q       <= init1_d;
               e2_q       <= init2_d;
               row0_q     <= init0_d;
               row1_q     <= init1_d;
               row2_q     <= init2_d;
               curX_q     <= minX_q;
               curY_q     <= minY_q;
               lastSeen_q <= 1'b0;
               state_q    <= SCAN;
            end
            SCAN: begin
               if (!lastSeen_q) begin
                  if (advance_d) begin
                     pixValid_q <= covered_d;
                     if (covered_d) begin
                        pixX_q <= curX_q;
                        pixY_q <= curY_q;
                     end
                     if (lastCand_d) begin
                        lastSeen_q <= 1'b1;
                     end else if (curX_q == maxX_q) begin
                        curX_q <= minX_q;
                        curY_q <= curY_q + CNT_ONE;
                        e0_q   <= row0_q + stepY0_q;
                        e1_q   <= row1_q + stepY1_q;
                        e2_q   <= row2_q + stepY2_q;
                        row0_q <= row0_q + stepY0_q;
                        row1_q <= row1_q + stepY1_q;
                        row2_q <= row2_q + stepY2_q;
                     end else begin
                        curX_q <= curX_q + CNT_ONE;
                        e0_q   <= e0_q + stepX0_q;
                        e1_q   <= e1_q + stepX1_q;
                        e2_q   <= e2_q + stepX2_q;
                     end
                  end
               end else if (advance_d) begin
                  pixValid_q <= 1'b0;
                  triDone_q  <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               triDone_q  <= 1'b0;
               triReady_q <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rasterBus.tri_ready = triReady_q;
   assign rasterBus.pix_valid = pixValid_q;
   assign rasterBus.pix_x     = 16'(pixX_q);
   assign rasterBus.pix_y     = 16'(pixY_q);
   assign busy_o              = busy_q;
   assign tri_done_o          = triDone_q;
endmodule
